// File: rtl/regfile_transfer_sequencer.sv
// Command-driven initiator that bulk-loads a byte stream into consecutive register-file
// entries (LOAD) or streams consecutive entries back out (DUMP) over the write/A-read ports.
module regfile_transfer_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_OP,
  input  logic [ADDR_W-1:0] CMD_BASE,
  input  logic [ADDR_W-1:0] CMD_COUNT,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [ADDR_W-1:0] RF_DR,
  output logic              RF_LD,
  output logic [DATA_W-1:0] RF_D,
  output logic [ADDR_W-1:0] RF_SA,
  input  logic [DATA_W-1:0] RF_DATA_A,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP_RD,
    S_DUMP_OUT,
    S_FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   out_q, out_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    out_d     = out_q;
    CMD_READY = 1'b0;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    RF_DR     = '0;
    RF_LD     = 1'b0;
    RF_D      = '0;
    RF_SA     = '0;
    DONE      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          ptr_d   = CMD_BASE;
          rem_d   = CMD_COUNT;
          state_d = CMD_OP ? S_DUMP_RD : S_LOAD;
        end
      end
      S_LOAD: begin
        // The write lands on the same edge as the input handshake.
        IN_READY = 1'b1;
        RF_DR    = ptr_q;
        RF_D     = IN_DATA;
        RF_LD    = IN_VALID;
        if (IN_VALID) begin
          ptr_d = ptr_q + ADDR_W'(1);
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == '0) state_d = S_FINISH;
        end
      end
      S_DUMP_RD: begin
        RF_SA   = ptr_q;
        out_d   = RF_DATA_A;
        state_d = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - ADDR_W'(1);
          state_d = (rem_q == '0) ? S_FINISH : S_DUMP_RD;
        end
      end
      S_FINISH: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign OUT_DATA = out_q;
  assign BUSY     = (state_q != S_IDLE);

endmodule
